// File: rtl/seg_scan_capture.sv
// Receive-side monitor for the multiplexed 4-digit seven-segment bus: recovers per-digit BCD values and frames.
// Optional macro SEGCAP_BLANK_DETECT_EN: the all-off pattern decodes to 4'hA instead of being an error.
module seg_scan_capture #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  anode_active,
   input  logic [6:0]  segments,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic        seg_error,
   output logic [1:0]  error_digit
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [7:0] CAP_CNT = 8'(SETTLE_CYCLES - 1);

   logic [3:0] r_anode, p_anode;
   logic [6:0] r_seg, p_seg;
   state_t     state_reg, state_next;
   logic [7:0] stable_cnt, stable_cnt_next;
   logic [1:0] expect_reg;
   logic       frame_err;
   logic       sel_valid;
   logic [1:0] sel_idx;
   logic       same;
   logic       capture;
   logic [3:0] dec_val;
   logic       dec_err;

   // Returns {error, value} for an active-low a..g pattern.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: decode = 5'h00;
         7'b1001111: decode = 5'h01;
         7'b0010010: decode = 5'h02;
         7'b0000110: decode = 5'h03;
         7'b1001100: decode = 5'h04;
         7'b0100100: decode = 5'h05;
         7'b0100000: decode = 5'h06;
         7'b0001111: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0000100: decode = 5'h09;
`ifdef SEGCAP_BLANK_DETECT_EN
         7'b1111111: decode = 5'h0A;
`else
         7'b1111111: decode = 5'h1F;
`endif
         default:    decode = 5'h1F;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_anode <= 4'hF;
         r_seg   <= 7'h7F;
         p_anode <= 4'hF;
         p_seg   <= 7'h7F;
      end else begin
         r_anode <= anode_active;
         r_seg   <= segments;
         p_anode <= r_anode;
         p_seg   <= r_seg;
      end
   end

   always_comb begin
      sel_valid = 1'b1;
      sel_idx   = 2'd0;
      case (r_anode)
         4'b0111: sel_idx = 2'd3;
         4'b1011: sel_idx = 2'd2;
         4'b1101: sel_idx = 2'd1;
         4'b1110: sel_idx = 2'd0;
         default: sel_valid = 1'b0;
      endcase
   end

   assign {dec_err, dec_val} = decode(r_seg);
   assign same = ({r_anode, r_seg} == {p_anode, p_seg});

   // Counter value after this edge decides capture, so the capture edge lands SETTLE_CYCLES after registration.
   always_comb begin
      state_next      = state_reg;
      stable_cnt_next = 8'd0;
      capture         = 1'b0;
      if (!sel_valid) begin
         state_next = IDLE;
      end else begin
         if (same) begin
            stable_cnt_next = (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;
         end
         if (state_reg == HELD && same) begin
            state_next = HELD;
         end else if (stable_cnt_next == CAP_CNT) begin
            capture    = 1'b1;
            state_next = HELD;
         end else begin
            state_next = SETTLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         stable_cnt <= 8'd0;
      end else begin
         state_reg  <= state_next;
         stable_cnt <= stable_cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] nibble_reg;
         logic       valid_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               nibble_reg <= 4'h0;
               valid_reg  <= 1'b0;
            end else if (capture && sel_idx == 2'(gi)) begin
               nibble_reg <= dec_val;
               valid_reg  <= 1'b1;
            end
         end
         assign digits[gi*4 +: 4] = nibble_reg;
         assign digit_valid[gi]   = valid_reg;
      end
   endgenerate

   // frame_err starts set so no frame completes before a digit3 has been seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expect_reg  <= 2'd0;
         frame_err   <= 1'b1;
         frame_valid <= 1'b0;
         seg_error   <= 1'b0;
         error_digit <= 2'd0;
      end else begin
         frame_valid <= 1'b0;
         if (capture) begin
            if (sel_idx == 2'd3) begin
               expect_reg <= 2'd2;
               frame_err  <= dec_err;
            end else if (sel_idx == expect_reg) begin
               expect_reg <= sel_idx - 2'd1;
               frame_err  <= frame_err | dec_err;
            end else begin
               frame_err  <= 1'b1;
            end
            frame_valid <= (sel_idx == 2'd0) && (expect_reg == 2'd0) && !frame_err && !dec_err;
            if (dec_err) begin
               error_digit <= sel_idx;
            end
         end
         if (capture && dec_err) begin
            seg_error <= 1'b1;
         end else if (err_clr) begin
            seg_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: pattern-age model with per-cycle compare plus literal checkpoints.
module tb_seg_scan_capture;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  anode_active = 4'hF;
   logic [6:0]  segments = 7'h7F;
   logic        err_clr = 1'b0;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        seg_error;
   logic [1:0]  error_digit;

   seg_scan_capture #(.SETTLE_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .anode_active(anode_active), .segments(segments),
      .err_clr(err_clr), .digits(digits), .digit_valid(digit_valid),
      .frame_valid(frame_valid), .seg_error(seg_error), .error_digit(error_digit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   int fv_cnt = 0;

   localparam logic [6:0] TBL [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic int mdec(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (TBL[i] == s) return i;
`ifdef SEGCAP_BLANK_DETECT_EN
      if (s == 7'h7F) return 10;
`endif
      return 15;
   endfunction

   function automatic int anode_idx(input logic [3:0] a);
      if ($countones(a) != 3) return -1;
      for (int i = 0; i < 4; i++) if (!a[i]) return i;
      return -1;
   endfunction

   // Model: a pattern is captured when it has sat in the input register for N consecutive edges.
   logic [3:0]  m_an;
   logic [6:0]  m_sg;
   int          m_age;
   logic [15:0] m_digits;
   logic [3:0]  m_dv;
   logic        m_fv, m_err;
   logic [1:0]  m_ed;
   logic [31:0] m_hist;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_an <= 4'hF; m_sg <= 7'h7F; m_age <= 0;
         m_digits <= 16'h0; m_dv <= 4'h0; m_fv <= 1'b0; m_err <= 1'b0; m_ed <= 2'd0;
         m_hist <= 32'hFFFFFFFF;
      end else begin : mstep
         int di, v;
         logic capt, ce;
         logic [15:0] d;
         logic [3:0] dv;
         logic [31:0] h;
         logic [7:0] code;
         di = anode_idx(m_an);
         capt = (di >= 0) && (m_age == N - 1);
         d = m_digits; dv = m_dv; h = m_hist; ce = 1'b0;
         if (capt) begin
            v = mdec(m_sg);
            ce = (v == 15);
            d[di*4 +: 4] = 4'(v);
            dv[di] = 1'b1;
            code = 8'(di) | (ce ? 8'h10 : 8'h00);
            h = {h[23:0], code};
         end
         m_digits <= d; m_dv <= dv; m_hist <= h;
         m_fv <= capt && (di == 0) && (h == 32'h03020100);
         if (capt && ce) begin
            m_err <= 1'b1;
            m_ed <= 2'(di);
         end else if (err_clr) begin
            m_err <= 1'b0;
         end
         m_age <= ({anode_active, segments} != {m_an, m_sg}) ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
         m_an <= anode_active;
         m_sg <= segments;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_digits", 32'(digits), 32'(m_digits));
         chk("cyc_digit_valid", 32'(digit_valid), 32'(m_dv));
         chk("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
         chk("cyc_seg_error", 32'(seg_error), 32'(m_err));
         chk("cyc_error_digit", 32'(error_digit), 32'(m_ed));
         if (frame_valid) fv_cnt++;
      end
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      anode_active = a;
      segments = s;
      $display("drive anode=%b segments=%b cycles=%0d", a, s, n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int fv0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_digits", 32'(digits), 32'h0);
      chk("reset_digit_valid", 32'(digit_valid), 32'h0);
      chk("reset_flags", 32'({frame_valid, seg_error, error_digit}), 32'h0);
      rst = 1'b0;

      // in-order frame 3,5,8,7
      fv0 = fv_cnt;
      drive(4'b0111, 7'b0000110, 6);
      drive(4'b1011, 7'b0100100, 6);
      drive(4'b1101, 7'b0000000, 6);
      drive(4'b1110, 7'b0001111, 6);
      drive(4'hF, 7'h7F, 6);
      chk("frame1_digits", 32'(digits), 32'h3587);
      chk("frame1_valid", 32'(digit_valid), 32'hF);
      chk("frame1_pulses", 32'(fv_cnt - fv0), 32'd1);

      // long hold on digit0: one capture, no frame
      fv0 = fv_cnt;
      drive(4'b1110, 7'b1001111, 100);
      chk("hold_digits", 32'(digits), 32'h3581);
      chk("hold_pulses", 32'(fv_cnt - fv0), 32'd0);

      // out-of-order 3,1,2,0 then in-order 3,2,1,0
      drive(4'b0111, 7'b0010010, 6);
      drive(4'b1101, 7'b1001100, 6);
      drive(4'b1011, 7'b0100000, 6);
      drive(4'b1110, 7'b0000100, 6);
      chk("ooo_digits", 32'(digits), 32'h2649);
      chk("ooo_pulses", 32'(fv_cnt - fv0), 32'd0);
      drive(4'b0111, 7'b0000001, 6);
      drive(4'b1011, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1110, 7'b0000110, 6);
      drive(4'hF, 7'h7F, 3);
      chk("inorder_digits", 32'(digits), 32'h0123);
      chk("inorder_pulses", 32'(fv_cnt - fv0), 32'd1);

      // undecodable pattern, clear, then clear colliding with a new error
      drive(4'b1011, 7'b1111110, 6);
      chk("err_nibble", 32'(digits[11:8]), 32'hF);
      chk("err_flag", 32'(seg_error), 32'd1);
      chk("err_digit", 32'(error_digit), 32'd2);
      drive(4'hF, 7'h7F, 2);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("err_cleared", 32'(seg_error), 32'd0);
      anode_active = 4'b1101;
      segments = 7'b1110000;
      $display("drive anode=%b segments=%b with err_clr on capture edge", anode_active, segments);
      repeat (4) @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("err_collide_flag", 32'(seg_error), 32'd1);
      chk("err_collide_digit", 32'(error_digit), 32'd1);
      drive(4'b1101, 7'b1110000, 2);

      // pattern toggling every 3 cycles is never captured
      for (int i = 0; i < 8; i++) drive(4'b1101, (i % 2 == 0) ? 7'b0000001 : 7'b1001111, 3);
      chk("toggle_digits", 32'(digits), 32'h0FF3);

      // reset mid-settle, then a full window is needed after release
      drive(4'b1101, 7'b0010010, 3);
      rst = 1'b1;
      #1;
      chk("midrst_digits", 32'(digits), 32'h0);
      chk("midrst_valid", 32'(digit_valid), 32'h0);
      chk("midrst_flags", 32'({frame_valid, seg_error, error_digit}), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(4'b1101, 7'b0010010, 4);
      chk("post_rst_early", 32'(digit_valid), 32'h0);
      drive(4'b1101, 7'b0010010, 2);
      chk("post_rst_digits", 32'(digits), 32'h0020);

      // blank digit3 followed by 1,2,3
      do_reset();
      fv0 = fv_cnt;
      drive(4'b0111, 7'b1111111, 6);
      drive(4'b1011, 7'b1001111, 6);
      drive(4'b1101, 7'b0010010, 6);
      drive(4'b1110, 7'b0000110, 6);
      drive(4'hF, 7'h7F, 3);
`ifdef SEGCAP_BLANK_DETECT_EN
      chk("blank_digits", 32'(digits), 32'hA123);
      chk("blank_pulses", 32'(fv_cnt - fv0), 32'd1);
      chk("blank_err", 32'(seg_error), 32'd0);
`else
      chk("blank_digits", 32'(digits), 32'hF123);
      chk("blank_pulses", 32'(fv_cnt - fv0), 32'd0);
      chk("blank_err", 32'(seg_error), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
